// File: rtl/audio_pwm_tx.sv
// Audio PWM transmitter: sample FIFO feeding an 8-bit PWM generator.
// Each sample plays for one frame of 256 ticks, and a tick occurs every CLK_DIV clk.
//   state | meaning
//   IDLE  | amplifier off; waits for enable with a non-empty FIFO
//   PLAY  | amplifier on; one sample per frame, popped at frame boundaries
module audio_pwm_tx #(
  parameter int CLK_DIV = 4,
  parameter int DEPTH   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [7:0]               din,
  input  logic                     wr,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  input  logic                     clr_underrun,
  output logic                     underrun,
  output logic                     ampPWM,
  output logic                     ampSD
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [7:0]    DIV_MAX  = 8'(CLK_DIV - 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  typedef enum logic {IDLE, PLAY} state_t;
  state_t r_state, w_state_nxt;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [LW-1:0] r_level;
  logic [7:0]    r_sample, r_pcnt, r_div;
  logic          r_underrun, r_pwm;
  logic          w_push, w_pop, w_tick, w_boundary, w_start, w_uset;

  assign full     = (r_level == LVL_FULL);
  assign empty    = (r_level == '0);
  assign level    = r_level;
  assign underrun = r_underrun;
  assign ampPWM   = r_pwm;
  assign ampSD    = (r_state == PLAY);

  // A full FIFO rejects the write even when a pop frees a slot this cycle.
  assign w_push     = wr && !full;
  assign w_tick     = (r_state == PLAY) && (r_div == DIV_MAX);
  assign w_boundary = w_tick && (r_pcnt == 8'hFF);

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_start     = 1'b0;
    w_uset      = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable && !empty) begin
          w_state_nxt = PLAY;
          w_pop       = 1'b1;
          w_start     = 1'b1;
        end
      end
      PLAY: begin
        if (w_boundary) begin
          if (!enable)    w_state_nxt = IDLE;
          else if (!empty) w_pop      = 1'b1;
          else             w_uset     = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // The tick path also wraps pcnt 255->0 on the boundary that returns to IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sample   <= '0;
      r_pcnt     <= '0;
      r_div      <= '0;
      r_pwm      <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      if (w_pop) r_sample <= r_mem[r_rptr];
      if (w_start || r_state != PLAY) begin
        r_div  <= '0;
        r_pcnt <= '0;
      end else if (w_tick) begin
        r_div  <= '0;
        r_pcnt <= r_pcnt + 1'b1;
      end else begin
        r_div  <= r_div + 1'b1;
      end
      r_pwm <= (r_state == PLAY) && (r_pcnt < r_sample);
      if (w_uset)            r_underrun <= 1'b1;
      else if (clr_underrun) r_underrun <= 1'b0;
    end
  end
endmodule
